// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: Philips-I2S transmitter for the stereo DAC.
// Serialises a 24-bit mono sample (carried in a 32-bit word, upper byte ignored) MSB-first.
// The same sample goes out on both the left and right slots of a 64-BCLK frame.
// BCLK and LRCK are derived from clk. One sample is buffered through a valid/ready handshake.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   dac_data, dac_valid   sample word {8'h00, sample[23:0]} and its valid
//   dac_ready             holding register empty
//   bclk, lrck, sdata     I2S bit clock, word select (0 = left), serial data
//   frame_start           one-clk pulse at each frame boundary (sample load instant)
//   underrun              one-clk pulse when a frame starts with nothing buffered
module i2s_dac_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned AUDIO_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dac_data,
  input  logic        dac_valid,
  output logic        dac_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(2 * SLOT_BITS);
  localparam int unsigned PosW = CntW - 1;
  localparam int unsigned IdxW = $clog2(AUDIO_BITS);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0]       div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic                  fs_q, fs_d;
  logic                  un_q, un_d;
  logic [CntW-1:0]       bit_q, bit_d;
  logic                  hold_full_q, hold_full_d;
  logic [AUDIO_BITS-1:0] hold_q, hold_d;
  logic [AUDIO_BITS-1:0] frame_q, frame_d;
  logic [PosW-1:0]       pos;
  logic [IdxW-1:0]       idx;
  int unsigned           sel;

  // The upper byte of the DAC word carries no audio.
  logic unused_upper;
  assign unused_upper = ^dac_data[31:AUDIO_BITS];

  always_comb begin
    div_d       = div_q + 1'b1;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    fs_d        = 1'b0;
    un_d        = 1'b0;
    bit_d       = bit_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    frame_d     = frame_q;
    pos         = '0;
    sel         = 0;
    idx         = '0;

    // Accept only into an empty holding register; the frame-boundary load below only
    // fires when it is already full, so the two never collide.
    if (dac_valid && !hold_full_q) begin
      hold_d      = dac_data[AUDIO_BITS-1:0];
      hold_full_d = 1'b1;
    end

    if (div_q == DivLast) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        // Falling edge: advance bit position, update lrck and sdata together.
        bit_d  = bit_q + 1'b1;
        lrck_d = bit_d[CntW-1];
        pos    = bit_d[PosW-1:0];
        if (bit_d == '0) begin
          fs_d = 1'b1;
          if (hold_full_q) begin
            frame_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            un_d = 1'b1;
          end
        end
        // p=0 is the I2S one-bit delay; p=1 carries the MSB. p=0 never reads frame_q,
        // so the frame-boundary load cannot race with the data path.
        sel     = 32'(pos);
        idx     = IdxW'(AUDIO_BITS - sel);
        sdata_d = 1'b0;
        if (sel >= 1 && sel <= AUDIO_BITS) begin
          sdata_d = frame_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b1;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      un_q        <= 1'b0;
      bit_q       <= '1;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      fs_q        <= fs_d;
      un_q        <= un_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
    end
  end

  assign dac_ready   = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = un_q;

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Serialises the filter path's 32-bit DAC word (`{8'h00, audio[23:0]}`) onto a Philips-I2S link to the stereo DAC.
- It is the output-side counterpart of the ADC capture path.
- The mono filtered sample is sent identically on the left and right channels.
- Generates BCLK and LRCK from the system clock.
- Buffers one sample through a valid/ready handshake.
- Emits a per-frame tick that paces the filter pipeline.

Parameters:
- CLK_DIV, default 2: system-clock cycles per BCLK half-period, minimum 1. Default gives 48 kHz frames from a 12.288 MHz clk.
- SLOT_BITS, default 32: BCLK periods per channel slot. Fixed at 32, since the frame is 64 BCLKs.
- AUDIO_BITS, default 24: significant sample bits, sent MSB-first.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dac_data  in  32  `{8'h00, signed 24-bit sample}`; bits [31:24] ignored
- dac_valid  in  1  dac_data valid
- dac_ready  out  1  holding register empty; a sample is accepted when valid & ready
- bclk  out  1  I2S bit clock
- lrck  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data; changes on BCLK falling edge
- frame_start  out  1  one-clk pulse at start of each frame, i.e. the sample load instant
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty

Behaviour:
- Reset, all synchronous:
  - Outputs: bclk=0, lrck=1, sdata=0, dac_ready=1, frame_start=0, underrun=0.
  - Internal: div_cnt=0, bit_cnt=63, hold_full=0, hold=0, frame_reg=0.
- Reset asserted mid-frame aborts the frame immediately. The next frame begins cleanly after release.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and bclk toggles.
  - BCLK period = 2*CLK_DIV clk cycles.
  - First rising edge at cycle CLK_DIV after reset release; first falling edge at cycle 2*CLK_DIV.
- Rising-edge event (bclk 0→1): no other state changes.
- Falling-edge event (bclk 1→0), all registered in the same clk cycle as bclk←0:
  - bit_cnt ← bit_cnt+1, wrapping mod 64.
  - lrck ← 0 for new bit_cnt 0..31, 1 for 32..63.
  - sdata ← slot bit at position p = new bit_cnt mod 32:
    - p=0: 0 (I2S one-bit delay).
    - p=1..24: frame_reg[24-p], so MSB bit 23 is at p=1 and LSB bit 0 is at p=24.
    - p=25..31: 0.
- Frame boundary (falling edge where bit_cnt wraps 63→0):
  - frame_start=1 for that single clk.
  - If hold_full: frame_reg ← hold, hold_full ← 0.
  - Else: frame_reg unchanged (last sample repeats) and underrun=1 for that clk.
  - frame_reg is stable for all 64 bits; left and right carry the same sample.
- Handshake:
  - dac_ready = ~hold_full, driven combinationally from the register.
  - Accept (dac_valid & dac_ready): hold ← dac_data[23:0], hold_full ← 1.
  - Accept coinciding with a frame-boundary underrun: the boundary sees the old hold_full=0 and underruns; the accepted sample stays in hold for the next frame.
  - dac_valid while not ready: no effect; dac_data is not sampled.
  - At most one sample is consumed per frame; a producer faster than the frame rate is back-pressured.
- Latency: a sample accepted before a frame boundary appears as its MSB on sdata exactly one BCLK period, i.e. 2*CLK_DIV clks, after that boundary's falling edge.
- No arithmetic is applied; the sample is transmitted bit-exact in two's complement.

Test Plan:
- Reset check, CLK_DIV=2: hold reset 5 clks then release.
  - Outputs at reset values.
  - bclk rises at clk 2 and falls at clk 4.
  - frame_start pulses at clk 4 with lrck=0.
  - underrun pulses at clk 4, since nothing was loaded.
- Single sample: send 32'h00800001 before the first frame, then let one frame run with no further samples.
  - Left bits p=0..31 are 0, 1, 22×0, 1, then 7×0. Right slot is identical with lrck=1.
  - dac_ready returns to 1 at the frame_start cycle.
- Underrun repeat: send 0x00123456 (sdata MSB-first 0001_0010_0011_0100_0101_0110), then no further samples.
  - Second frame repeats the same 24 bits on both channels.
  - underrun pulses exactly at the second frame_start.
- Back-pressure: dac_valid held high with incrementing data 1, 2, 3, ….
  - Exactly one sample is accepted per frame, each immediately after frame_start.
  - Transmitted values are 1, 2, 3 in consecutive frames; none is skipped or duplicated.
- LRCK/BCLK timing, CLK_DIV=1 and CLK_DIV=3:
  - Frame length is 128*CLK_DIV clks.
  - lrck and sdata change only in the cycle bclk falls.
  - lrck transitions occur exactly at p=0.
- Reset mid-frame: assert reset at bit_cnt=40 for 1 clk, then send 0x00FFFFFF.
  - Immediate reset values.
  - The next frame_start arrives 2*CLK_DIV clks after release and carries 0xFFFFFF.
